c_drain_streamer: RTL and testbench

Read-side initiator for the C result SRAM port of the systolic wrapper (`c_rd_en`/`c_rd_re`/`c_rd_row`/`c_rd_col` → `c_rd_rdata`/`c_rd_rvalid`). On a drain pulse it walks the full M×N result tile in row-major order, issues one read per element with credit-based flow control, and buffers returns in a small FIFO. It presents the results as a valid/ready stream tagged with row, column and last. It sits between the tile engine's `done`/`C_valid` and the downstream writeback path.

---
 rtl/c_drain_pkg.sv | 20 ++
 rtl/c_drain_streamer_if.sv | 44 ++++
 rtl/c_drain_fifo.sv | 68 ++++++
 rtl/c_drain_streamer.sv | 192 +++++++++++++++++++
 tb/tb_c_drain_streamer.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/c_drain_pkg.sv
// ----------------------------------------------------------------------------
// c_drain_pkg
// Shared types for the C-tile drain streamer.
//   c_drain_state_e : drain FSM states (IDLE, ISSUE, DRAIN, DONE)
//   idx_width()     : index width for a dimension of n entries (min 1 bit)
// ----------------------------------------------------------------------------
package c_drain_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } c_drain_state_e;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/c_drain_streamer_if.sv
// ----------------------------------------------------------------------------
// c_drain_streamer_if
// Bundles the two buses of the drain streamer:
//   - C result SRAM read port : c_rd_en/c_rd_re/c_rd_row/c_rd_col out,
//                               c_rd_rdata/c_rd_rvalid back
//   - result stream           : out_valid/out_data/out_row/out_col/out_last
//                               out, out_ready back
// Modports:
//   master : the streamer (drives reads and the stream)
//   slave  : the SRAM responder / downstream consumer side
// ----------------------------------------------------------------------------
interface c_drain_streamer_if #(
    parameter int DATA_W = 32,
    parameter int ROW_W  = 3,
    parameter int COL_W  = 3
);
    logic              c_rd_en;
    logic              c_rd_re;
    logic [ROW_W-1:0]  c_rd_row;
    logic [COL_W-1:0]  c_rd_col;
    logic [DATA_W-1:0] c_rd_rdata;
    logic              c_rd_rvalid;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ROW_W-1:0]  out_row;
    logic [COL_W-1:0]  out_col;
    logic              out_last;

    modport master (
        output c_rd_en, c_rd_re, c_rd_row, c_rd_col,
        input  c_rd_rdata, c_rd_rvalid,
        output out_valid, out_data, out_row, out_col, out_last,
        input  out_ready
    );

    modport slave (
        input  c_rd_en, c_rd_re, c_rd_row, c_rd_col,
        output c_rd_rdata, c_rd_rvalid,
        input  out_valid, out_data, out_row, out_col, out_last,
        output out_ready
    );
endinterface

// File: rtl/c_drain_fifo.sv
// ----------------------------------------------------------------------------
// c_drain_fifo
// Synchronous first-word-fall-through FIFO holding read returns.
//   clk, rst : clock, asynchronous active-high reset (control only)
//   push     : write wdata (ignored when full unless popping the same cycle)
//   pop      : consume the head word (ignored when empty)
//   rdata    : head word, valid whenever empty is low
//   count    : number of stored words
//   empty    : no words stored
//   full     : DEPTH words stored
// ----------------------------------------------------------------------------
module c_drain_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);
    localparam int PTR_W = (DEPTH <= 1) ? 1 : $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO can still accept a word when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only, so it is not reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/c_drain_streamer.sv
// ----------------------------------------------------------------------------
// c_drain_streamer
// Drains an M x N result tile from the C SRAM read port in row-major order
// and re-emits it as a tagged valid/ready stream.
//   clk, rst      : clock, asynchronous active-high reset
//   drain_start   : pulse in IDLE starts a drain (ignored otherwise)
//   busy          : drain in progress
//   done          : one-cycle pulse after the last element is accepted
//   err_spurious  : sticky, read data returned with nothing outstanding
//   bus (master)  : SRAM read port and result stream
// Reads are only issued while outstanding reads plus buffered returns stay
// below FIFO_D, so the return FIFO can never overflow.
// ----------------------------------------------------------------------------
module c_drain_streamer
    import c_drain_pkg::*;
#(
    parameter int M      = 8,
    parameter int N      = 8,
    parameter int DATA_W = 32,
    parameter int ROW_W  = (M <= 1) ? 1 : $clog2(M),
    parameter int COL_W  = (N <= 1) ? 1 : $clog2(N),
    parameter int FIFO_D = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              drain_start,
    output logic              busy,
    output logic              done,
    output logic              err_spurious,
    c_drain_streamer_if.master bus
);
    localparam int CNT_W = $clog2(FIFO_D + 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(M - 1);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(N - 1);
    localparam logic [CNT_W:0]   CREDIT_MAX = (CNT_W + 1)'(FIFO_D);

    c_drain_state_e    state;
    logic [ROW_W-1:0]  iss_row;
    logic [COL_W-1:0]  iss_col;
    logic [ROW_W-1:0]  out_row_q;
    logic [COL_W-1:0]  out_col_q;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    in_flight;
    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_empty;
    logic              fifo_full;
    logic              start;
    logic              issue_fire;
    logic              issue_last;
    logic              rv_counted;
    logic              rv_spurious;
    logic              out_vld;
    logic              pop;
    logic              out_is_last;

    assign start       = (state == IDLE) && drain_start;
    assign in_flight   = {1'b0, fifo_count} + {1'b0, outstanding};
    assign issue_fire  = (state == ISSUE) && (in_flight < CREDIT_MAX) && !fifo_full;
    assign issue_last  = (iss_row == ROW_LAST) && (iss_col == COL_LAST);
    assign rv_counted  = bus.c_rd_rvalid && (outstanding != '0);
    assign rv_spurious = bus.c_rd_rvalid && (outstanding == '0);
    assign out_vld     = !fifo_empty;
    assign pop         = out_vld && bus.out_ready;
    assign out_is_last = (out_row_q == ROW_LAST) && (out_col_q == COL_LAST);

    // Read port is a direct decode of state and issue counters.
    assign bus.c_rd_en  = issue_fire;
    assign bus.c_rd_re  = issue_fire;
    assign bus.c_rd_row = iss_row;
    assign bus.c_rd_col = iss_col;

    // Stream outputs; data and last are masked to zero while nothing is held
    // so the idle/reset view is all zeros (also covers M*N == 1).
    assign bus.out_valid = out_vld;
    assign bus.out_data  = out_vld ? fifo_rdata : '0;
    assign bus.out_row   = out_row_q;
    assign bus.out_col   = out_col_q;
    assign bus.out_last  = out_vld && out_is_last;

    c_drain_fifo #(
        .DEPTH (FIFO_D),
        .WIDTH (DATA_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rv_counted),
        .pop   (pop),
        .wdata (bus.c_rd_rdata),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (drain_start) begin
                        state <= ISSUE;
                        busy  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (issue_fire && issue_last) state <= DRAIN;
                end
                DRAIN: begin
                    if (pop && out_is_last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Issue position, row-major with wrap back to the origin after the last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_row <= '0;
            iss_col <= '0;
        end else if (start) begin
            iss_row <= '0;
            iss_col <= '0;
        end else if (issue_fire) begin
            if (iss_col == COL_LAST) begin
                iss_col <= '0;
                iss_row <= (iss_row == ROW_LAST) ? '0 : iss_row + 1'b1;
            end else begin
                iss_col <= iss_col + 1'b1;
            end
        end
    end

    // Output tags: returns are in order, so a second row-major counter
    // stepping on each handshake labels the element at the FIFO head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_row_q <= '0;
            out_col_q <= '0;
        end else if (start) begin
            out_row_q <= '0;
            out_col_q <= '0;
        end else if (pop) begin
            if (out_col_q == COL_LAST) begin
                out_col_q <= '0;
                out_row_q <= (out_row_q == ROW_LAST) ? '0 : out_row_q + 1'b1;
            end else begin
                out_col_q <= out_col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({issue_fire, rv_counted})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // A stray return in the same cycle as a start still flags the error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_spurious <= 1'b0;
        end else if (rv_spurious) begin
            err_spurious <= 1'b1;
        end else if (start) begin
            err_spurious <= 1'b0;
        end
    end

endmodule

// File: tb/tb_c_drain_streamer.sv
// ----------------------------------------------------------------------------
// tb_c_drain_streamer
// Bench for c_drain_streamer (M=N=4, FIFO_D=4). A responder process models
// the SRAM with in-order, variable-latency returns; starting a drain pushes
// the whole tile, row-major, into an expected queue; a monitor process pops
// and compares on every stream handshake and checks the done pulse.
// ----------------------------------------------------------------------------
module tb_c_drain_streamer;

    localparam int M      = 4;
    localparam int N      = 4;
    localparam int DATA_W = 32;
    localparam int ROW_W  = 2;
    localparam int COL_W  = 2;
    localparam int FIFO_D = 4;
    localparam int TOT    = M * N;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                row;
        int                col;
        bit                last;
    } exp_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;
    logic drain_start;
    logic busy;
    logic done;
    logic err_spurious;

    c_drain_streamer_if #(.DATA_W(DATA_W), .ROW_W(ROW_W), .COL_W(COL_W)) bus ();

    c_drain_streamer #(
        .M(M), .N(N), .DATA_W(DATA_W), .ROW_W(ROW_W), .COL_W(COL_W), .FIFO_D(FIFO_D)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .drain_start  (drain_start),
        .busy         (busy),
        .done         (done),
        .err_spurious (err_spurious),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] sram [M][N];
    exp_t exp_q[$];
    rsp_t rsp_q[$];

    int cyc         = 0;
    int lat         = 1;
    int jit         = 0;
    int ready_pct   = 100;
    int spur_req    = 0;
    int spur_ack    = 0;
    int issued      = 0;
    int popped      = 0;
    int credit_base = 0;
    bit credit_bad  = 1'b0;
    int done_cnt    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // SRAM responder: a read seen at this falling edge issues at the next
    // rising edge and returns lat (+ jitter) cycles later, never reordered.
    initial begin : responder
        bus.c_rd_rvalid = 1'b0;
        bus.c_rd_rdata  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst === 1'b1) begin
                rsp_q.delete();
                bus.c_rd_rvalid = 1'b0;
                credit_base     = issued - popped;
            end else begin
                if (bus.c_rd_en === 1'b1) begin
                    rsp_t r;
                    r.data = sram[int'(bus.c_rd_row)][int'(bus.c_rd_col)];
                    r.due  = cyc + lat + $urandom_range(0, jit);
                    if (rsp_q.size() > 0 && r.due < rsp_q[$].due) r.due = rsp_q[$].due;
                    rsp_q.push_back(r);
                    issued++;
                    if (issued - popped - credit_base > FIFO_D) credit_bad = 1'b1;
                end
                if (spur_req != spur_ack) begin
                    spur_ack        = spur_req;
                    bus.c_rd_rvalid = 1'b1;
                    bus.c_rd_rdata  = $urandom;
                end else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                    bus.c_rd_rvalid = 1'b1;
                    bus.c_rd_rdata  = rsp_q[0].data;
                    void'(rsp_q.pop_front());
                end else begin
                    bus.c_rd_rvalid = 1'b0;
                    bus.c_rd_rdata  = $urandom;
                end
            end
        end
    end

    // Monitor: drives out_ready, scores handshakes, checks hold and done.
    initial begin : monitor
        bit                had_stall;
        bit                last_taken;
        logic [DATA_W-1:0] held_data;
        logic [ROW_W-1:0]  held_row;
        logic [COL_W-1:0]  held_col;
        logic              held_last;
        had_stall     = 1'b0;
        last_taken    = 1'b0;
        held_data     = '0;
        held_row      = '0;
        held_col      = '0;
        held_last     = 1'b0;
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            bus.out_ready = ($urandom_range(1, 100) <= ready_pct);
            if (rst === 1'b1) begin
                had_stall  = 1'b0;
                last_taken = 1'b0;
            end else begin
                if (done === 1'b1 || last_taken) begin
                    check("done_pulse", done, last_taken);
                    if (done === 1'b1) begin
                        done_cnt++;
                        check("busy_at_done", busy, 0);
                    end
                end
                last_taken = 1'b0;
                if (had_stall) begin
                    check("hold_valid", bus.out_valid, 1);
                    check("hold_tag", {bus.out_data, bus.out_row, bus.out_col, bus.out_last},
                          {held_data, held_row, held_col, held_last});
                end
                if (bus.out_valid === 1'b1 && bus.out_ready) begin
                    popped++;
                    had_stall = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got data %0h row %0d col %0d, expected no output",
                                 bus.out_data, bus.out_row, bus.out_col);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("out_data", bus.out_data, e.data);
                        check("out_row", bus.out_row, e.row);
                        check("out_col", bus.out_col, e.col);
                        check("out_last", bus.out_last, e.last);
                        last_taken = e.last;
                    end
                end else if (bus.out_valid === 1'b1) begin
                    had_stall = 1'b1;
                    held_data = bus.out_data;
                    held_row  = bus.out_row;
                    held_col  = bus.out_col;
                    held_last = bus.out_last;
                end else begin
                    had_stall = 1'b0;
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err_spurious, 0);
        check({tag, "_rd_en"}, bus.c_rd_en, 0);
        check({tag, "_rd_re"}, bus.c_rd_re, 0);
        check({tag, "_rd_row"}, bus.c_rd_row, 0);
        check({tag, "_rd_col"}, bus.c_rd_col, 0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_out_data"}, bus.out_data, 0);
        check({tag, "_out_row"}, bus.out_row, 0);
        check({tag, "_out_col"}, bus.out_col, 0);
        check({tag, "_out_last"}, bus.out_last, 0);
    endtask

    int iss0, pop0, done0, t0;

    // New random tile, expected stream queued, then a one-cycle start pulse.
    task automatic start_drain(input string tag);
        for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++)
                sram[r][c] = $urandom;
        for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++) begin
                exp_t e;
                e.data = sram[r][c];
                e.row  = r;
                e.col  = c;
                e.last = (r == M - 1) && (c == N - 1);
                exp_q.push_back(e);
            end
        iss0  = issued;
        pop0  = popped;
        done0 = done_cnt;
        t0    = cyc;
        drain_start = 1'b1;
        @(negedge clk);
        drain_start = 1'b0;
        check({tag, "_busy_start"}, busy, 1);
        check({tag, "_first_rd_en"}, bus.c_rd_en, 1);
        check({tag, "_first_rd_addr"}, {bus.c_rd_row, bus.c_rd_col}, 0);
    endtask

    task automatic wait_done(input string tag, input int max_cycles);
        int t;
        t = 0;
        while (done !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_done_seen"}, done, 1);
        if (max_cycles > 0) check({tag, "_throughput"}, (cyc - t0 <= max_cycles), 1);
        cycles(2);
        check({tag, "_all_drained"}, exp_q.size(), 0);
        check({tag, "_reads"}, issued - iss0, TOT);
        check({tag, "_outputs"}, popped - pop0, TOT);
        check({tag, "_one_done"}, done_cnt - done0, 1);
        check({tag, "_credit"}, credit_bad, 0);
        check({tag, "_idle_busy"}, busy, 0);
    endtask

    initial begin : main
        rst         = 1'b1;
        drain_start = 1'b0;
        cycles(3);
        check_reset_values("reset");
        rst = 1'b0;
        cycles(2);

        // Fixed latency 1 and 3, always ready: one read per cycle.
        ready_pct = 100;
        jit       = 0;
        lat       = 1;
        start_drain("lat1");
        wait_done("lat1", TOT + lat + 6);
        lat = 3;
        start_drain("lat3");
        wait_done("lat3", TOT + lat + 6);

        // Back-pressure: consumer stalled, issue must stop at FIFO_D reads.
        lat       = 1;
        ready_pct = 0;
        start_drain("bp");
        cycles(12);
        check("bp_reads_capped", issued - iss0, FIFO_D);
        check("bp_rd_en_low", bus.c_rd_en, 0);
        check("bp_head_valid", bus.out_valid, 1);
        check("bp_head_tag", {bus.out_row, bus.out_col}, 0);
        ready_pct = 100;
        wait_done("bp", 0);

        // Random latency jitter and random ready.
        for (int k = 0; k < 3; k++) begin
            lat       = 1 + k;
            jit       = 3;
            ready_pct = 40 + 20 * k;
            start_drain("rand");
            wait_done("rand", 0);
        end

        // A second start pulse mid-drain is ignored.
        lat       = 2;
        jit       = 1;
        ready_pct = 70;
        start_drain("restart");
        cycles(5);
        drain_start = 1'b1;
        @(negedge clk);
        drain_start = 1'b0;
        wait_done("restart", 0);
        cycles(4);
        check("restart_no_second_done", done_cnt - done0, 1);

        // Stray return while idle: flagged, nothing emitted, start clears it.
        pop0 = popped;
        spur_req++;
        cycles(3);
        check("spur_err_set", err_spurious, 1);
        check("spur_no_output", bus.out_valid, 0);
        check("spur_no_pop", popped - pop0, 0);
        jit       = 0;
        lat       = 1;
        ready_pct = 100;
        start_drain("spur");
        check("spur_err_cleared", err_spurious, 0);
        wait_done("spur", 0);

        // Reset after 5 outputs: everything returns to reset values, no done.
        lat       = 2;
        ready_pct = 100;
        start_drain("rstmid");
        begin
            int t;
            t = 0;
            while (popped - pop0 < 5 && t < 200) begin
                @(negedge clk);
                t++;
            end
            check("rstmid_reached_5", (popped - pop0 >= 5), 1);
        end
        rst = 1'b1;
        #1;
        check_reset_values("rstmid");
        cycles(3);
        exp_q.delete();
        done0 = done_cnt;
        rst = 1'b0;
        cycles(4);
        check("rstmid_no_done", done_cnt - done0, 0);
        check_reset_values("post_rst");
        start_drain("fresh");
        wait_done("fresh", TOT + lat + 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
